simpletron_memory: RTL and testbench
====================================

SIMPLETRON_MEMORY -- requirements
Module: simpletron_memory

Interface
REQ-001 The block SHALL have parameter LOAD_LEN, default 32, giving the number of words written per load session (range 1..32).
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port cpu_bus, input, 14, processor bus: bit 13 write strobe, bits 12:8 word address, bits 7:0 write data.
REQ-005 The block SHALL have port cpu_data, output, 8, word at address cpu_bus[12:8], fed to the processor instruction/data input.
REQ-006 The block SHALL have port cpu_reset, output, 1, high holds the processor in reset.
REQ-007 The block SHALL have port ld_start, input, 1, single-cycle request to begin a load session.
REQ-008 The block SHALL have port ld_valid, input, 1, loader byte valid.
REQ-009 The block SHALL have port ld_data, input, 8, loader byte.
REQ-010 The block SHALL have port ld_ready, output, 1, block accepts a loader byte this cycle.
REQ-011 The block SHALL have port load_done, output, 1, one-cycle pulse on completing a load session.
REQ-012 The block SHALL have port state, output, 2, current FSM state (00 IDLE, 01 LOAD, 10 RUN).

Function
REQ-013 The block SHALL hold 32 words x 8 bits, addressed 0..31.
REQ-014 The block SHALL drive cpu_data combinationally from the array at cpu_bus[12:8] in every state; there is zero read latency.
REQ-015 A word written at edge N SHALL appear on cpu_data from edge N onward; there is no same-cycle bypass.
REQ-016 The FSM SHALL have states IDLE, LOAD and RUN; encoding 11 is unreachable and, if ever entered, SHALL return to IDLE at the next edge.
REQ-017 In IDLE: cpu_reset=1 and ld_ready=0; ld_start=1 SHALL move to LOAD with load pointer cleared to 0.
REQ-018 In LOAD: cpu_reset=1 and ld_ready=1; each cycle with ld_valid=1 SHALL write ld_data to the word at the load pointer and increment the pointer.
REQ-019 In LOAD, a handshake at pointer LOAD_LEN-1 SHALL write that word, move to RUN, and assert load_done for the next cycle only.
REQ-020 In LOAD, cycles with ld_valid=0 SHALL leave the array and the pointer unchanged; idle gaps have no limit.
REQ-021 In LOAD, ld_start SHALL be ignored.
REQ-022 Words at addresses >= LOAD_LEN SHALL keep their prior contents during a load session.
REQ-023 In RUN: cpu_reset=0 and ld_ready=0; cpu_bus[13]=1 SHALL write cpu_bus[7:0] to the word at cpu_bus[12:8] at that edge.
REQ-024 In RUN, ld_start=1 SHALL move to LOAD with the pointer cleared to 0; that same cycle's processor write SHALL still commit.
REQ-025 Processor writes (cpu_bus[13]=1) SHALL be ignored in IDLE and LOAD.
REQ-026 ld_valid and ld_data SHALL be ignored outside LOAD.
REQ-027 cpu_reset, ld_ready and state SHALL be decoded from the state register only, with no combinational path from any input.
REQ-028 The load pointer SHALL be 5 bits and SHALL NOT wrap within a session; a session always terminates at LOAD_LEN-1.

Reset
REQ-029 On reset=1 at an edge, the block SHALL go to IDLE, clear the pointer, clear load_done, and clear all 32 words to 8'h00, in any state including mid-load.
REQ-030 The output values after reset SHALL be: state=00, cpu_reset=1, ld_ready=0, load_done=0, and cpu_data=8'h00 for every address.
REQ-031 Reset SHALL take priority over ld_start, ld_valid and processor writes in the same cycle.

Verification
REQ-032 Reset, then any cpu_bus address -> cpu_data=8'h00, cpu_reset=1, ld_ready=0, state=00.
REQ-033 ld_start, then 32 bytes 8'h20+i with ld_valid deasserted every third cycle -> word i=8'h20+i; state=10 and load_done=1 exactly one cycle after the 32nd handshake; cpu_reset=0 thereafter.
REQ-034 In RUN, cpu_bus=14'b1_00101_10101010 for one cycle, then cpu_bus=14'b0_00101_00000000 -> cpu_data=8'hAA.
REQ-035 In LOAD with pointer at 3, cpu_bus=14'b1_00011_11111111 and ld_valid=0 -> word 3 unchanged and pointer still 3.
REQ-036 Reset asserted after 10 load handshakes -> state=00, all words 8'h00, and a subsequent load restarts at address 0.
REQ-037 Connected to the processor and loaded with {8'hDE,8'h9F,8'hFD,8'h00} at 0..3, 8'h05 at 30 and 8'h07 at 31 -> after run, word 29=8'h0C.

Source files
------------

// File: rtl/simpletron_memory.sv
// 32 x 8 program/data memory for the Simpletron. The loader fills it while the
// processor is held in reset, then releases the processor to run from it.
//   state | meaning
//   IDLE  | processor in reset, waiting for ld_start
//   LOAD  | processor in reset, loader bytes written at the load pointer
//   RUN   | processor released, processor writes land in the array
module simpletron_memory #(
    parameter int unsigned LOAD_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] cpu_bus,
    output logic [7:0]  cpu_data,
    output logic        cpu_reset,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        load_done,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_BAD  = 2'b11
    } state_t;

    localparam logic [4:0] LAST_PTR = 5'(LOAD_LEN - 1);

    state_t     state_q, state_d;
    logic [4:0] ptr_q, ptr_d;
    logic       done_q, done_d;
    logic [7:0] mem_q [32];

    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;

    logic       cpu_wr;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata;

    assign cpu_wr    = cpu_bus[13];
    assign cpu_addr  = cpu_bus[12:8];
    assign cpu_wdata = cpu_bus[7:0];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = cpu_addr;
        wr_data = cpu_wdata;
        case (state_q)
            S_IDLE: begin
                if (ld_start) begin
                    state_d = S_LOAD;
                    ptr_d   = 5'd0;
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = ptr_q;
                    wr_data = ld_data;
                    // The session ends on the last handshake; the pointer never wraps.
                    if (ptr_q == LAST_PTR) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 5'd1;
                    end
                end
            end
            S_RUN: begin
                wr_en = cpu_wr;
                if (ld_start) begin
                    state_d = S_LOAD;
                    ptr_d   = 5'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 5'd0;
            done_q  <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            if (wr_en) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

    // Outputs decode registers only, so no input reaches them combinationally
    // except the read port, which is intentionally zero-latency.
    assign cpu_data  = mem_q[cpu_addr];
    assign cpu_reset = (state_q != S_RUN);
    assign ld_ready  = (state_q == S_LOAD);
    assign load_done = done_q;
    assign state     = state_q;

endmodule

// File: tb/tb_simpletron_memory.sv
// Directed bench for simpletron_memory: a vector table for the basic IDLE/LOAD
// behaviour, then hand-written sequences for reset mid-load, full load and RUN.
module tb_simpletron_memory;

    logic        clk;
    logic        reset;
    logic [13:0] cpu_bus;
    logic [7:0]  cpu_data;
    logic        cpu_reset;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        load_done;
    logic [1:0]  state;

    int checks   = 0;
    int failures = 0;

    simpletron_memory #(.LOAD_LEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_bus   (cpu_bus),
        .cpu_data  (cpu_data),
        .cpu_reset (cpu_reset),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .load_done (load_done),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [13:0] bus;
        logic        st;
        logic        vl;
        logic [7:0]  dt;
        logic [1:0]  e_state;
        logic        e_cres;
        logic        e_rdy;
        logic        e_done;
        logic [7:0]  e_data;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [13:0] bus, input logic st,
                        input logic vl, input logic [7:0] dt);
        @(negedge clk);
        reset    = rst;
        cpu_bus  = bus;
        ld_start = st;
        ld_valid = vl;
        ld_data  = dt;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        cpu_bus  = {1'b0, bus[12:0]};
    endtask

    task automatic peek(input string name, input logic [4:0] addr, input logic [7:0] exp);
        cpu_bus = {1'b0, addr, 8'h00};
        #1;
        chk(name, {24'd0, cpu_data}, {24'd0, exp});
    endtask

    task automatic chk_ctl(input string name, input logic [1:0] st, input logic cres,
                           input logic rdy, input logic dn);
        chk({name, ".state"},     {30'd0, state},  {30'd0, st});
        chk({name, ".cpu_reset"}, {31'd0, cpu_reset}, {31'd0, cres});
        chk({name, ".ld_ready"},  {31'd0, ld_ready},  {31'd0, rdy});
        chk({name, ".load_done"}, {31'd0, load_done}, {31'd0, dn});
    endtask

    initial begin
        int hs;
        reset    = 1'b1;
        cpu_bus  = '0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;

        //          rst  bus                     st  vl  dt     state  cr rdy dn data
        vecs[0] = '{1'b1, 14'b0_00000_00000000, 0, 0, 8'h00, 2'b00, 1, 0, 0, 8'h00};
        vecs[1] = '{1'b0, 14'b1_00100_01010101, 0, 0, 8'h00, 2'b00, 1, 0, 0, 8'h00};
        vecs[2] = '{1'b0, 14'b0_00000_00000000, 1, 1, 8'h77, 2'b01, 1, 1, 0, 8'h00};
        vecs[3] = '{1'b0, 14'b0_00000_00000000, 0, 1, 8'h11, 2'b01, 1, 1, 0, 8'h11};
        vecs[4] = '{1'b0, 14'b0_00001_00000000, 0, 0, 8'h99, 2'b01, 1, 1, 0, 8'h00};
        vecs[5] = '{1'b0, 14'b0_00001_00000000, 1, 1, 8'h22, 2'b01, 1, 1, 0, 8'h22};
        vecs[6] = '{1'b0, 14'b1_00011_11111111, 0, 1, 8'h33, 2'b01, 1, 1, 0, 8'h00};
        vecs[7] = '{1'b0, 14'b1_00011_11111111, 0, 0, 8'h00, 2'b01, 1, 1, 0, 8'h00};
        vecs[8] = '{1'b0, 14'b0_00011_00000000, 0, 1, 8'h44, 2'b01, 1, 1, 0, 8'h44};

        for (int v = 0; v < 9; v++) begin
            step(vecs[v].rst, vecs[v].bus, vecs[v].st, vecs[v].vl, vecs[v].dt);
            chk_ctl($sformatf("vec%0d", v), vecs[v].e_state, vecs[v].e_cres,
                    vecs[v].e_rdy, vecs[v].e_done);
            chk($sformatf("vec%0d.cpu_data", v), {24'd0, cpu_data}, {24'd0, vecs[v].e_data});
        end
        peek("vec.word2", 5'd2, 8'h33);

        // Reset mid-load after 10 handshakes, with competing start/valid/write.
        step(1'b1, '0, 1'b0, 1'b0, 8'h00);
        step(1'b0, '0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, 1'b1, 8'hA0 + 8'(i));
        peek("midload.word9", 5'd9, 8'hA9);
        step(1'b1, 14'b1_00010_11110000, 1'b1, 1'b1, 8'h5C);
        chk_ctl("midreset", 2'b00, 1'b1, 1'b0, 1'b0);
        for (int a = 0; a < 32; a++) peek($sformatf("midreset.word%0d", a), 5'(a), 8'h00);
        step(1'b0, '0, 1'b1, 1'b0, 8'h00);
        step(1'b0, '0, 1'b0, 1'b1, 8'hC3);
        peek("restart.word0", 5'd0, 8'hC3);
        peek("restart.word1", 5'd1, 8'h00);

        // Full 32-byte load with ld_valid dropped every third cycle.
        step(1'b1, '0, 1'b0, 1'b0, 8'h00);
        step(1'b0, '0, 1'b1, 1'b0, 8'h00);
        hs = 0;
        for (int c = 0; c < 64 && hs < 32; c++) begin
            if (c % 3 == 2) begin
                step(1'b0, '0, 1'b0, 1'b0, 8'hEE);
            end else begin
                step(1'b0, '0, 1'b0, 1'b1, 8'h20 + 8'(hs));
                hs++;
                if (hs == 31) chk_ctl("load31", 2'b01, 1'b1, 1'b1, 1'b0);
            end
        end
        chk("load.handshakes", hs, 32);
        chk_ctl("load.done", 2'b10, 1'b0, 1'b0, 1'b1);
        for (int a = 0; a < 32; a++) peek($sformatf("load.word%0d", a), 5'(a), 8'h20 + 8'(a));

        // RUN: processor write, then read back; loader inputs ignored.
        step(1'b0, 14'b1_00101_10101010, 1'b0, 1'b1, 8'hEE);
        chk_ctl("run.after", 2'b10, 1'b0, 1'b0, 1'b0);
        peek("run.word5", 5'd5, 8'hAA);
        peek("run.word0", 5'd0, 8'h20);
        peek("run.word31", 5'd31, 8'h3F);

        // ld_start in RUN re-enters LOAD while the same-cycle write commits.
        step(1'b0, 14'b1_00110_01011010, 1'b1, 1'b0, 8'h00);
        chk_ctl("reload", 2'b01, 1'b1, 1'b1, 1'b0);
        peek("reload.word6", 5'd6, 8'h5A);
        step(1'b0, 14'b1_00111_11001100, 1'b0, 1'b1, 8'h01);
        peek("reload.word0", 5'd0, 8'h01);
        peek("reload.word7", 5'd7, 8'h27);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
